// File: rtl/phase_seq_gen.sv
// Multi-phase instruction-cycle sequencer: IDLE/RUN/HALTED FSM with fetch/ALU strobes.
// Define PHASE_SEQ_CYCLE_CNT_EN to build the 16-bit started-cycle counter.
module phase_seq_gen #(
  parameter int unsigned NUM_PHASES = 8,
  parameter int unsigned FETCH_LEN  = 4,
  parameter int unsigned ALU_PHASE  = 5,
  parameter int unsigned PH_W       = 4
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            halt,
  input  logic            step,
  output logic            clk,
  output logic            fetch,
  output logic            alu_ena,
  output logic [PH_W-1:0] phase,
  output logic            cycle_start,
  output logic [15:0]     cycle_cnt
);

  if (NUM_PHASES < 2 || NUM_PHASES > 16) begin : g_np_chk
    $error("phase_seq_gen: NUM_PHASES must be 2..16");
  end
  if (FETCH_LEN < 1 || FETCH_LEN > NUM_PHASES - 1) begin : g_fl_chk
    $error("phase_seq_gen: FETCH_LEN must be 1..NUM_PHASES-1");
  end
  if (ALU_PHASE < FETCH_LEN || ALU_PHASE > NUM_PHASES - 1) begin : g_alu_chk
    $error("phase_seq_gen: ALU_PHASE must be FETCH_LEN..NUM_PHASES-1");
  end
  if (PH_W < 1 || PH_W < $clog2(NUM_PHASES)) begin : g_phw_chk
    $error("phase_seq_gen: PH_W too narrow for NUM_PHASES");
  end

  localparam logic [PH_W-1:0] LAST_PH   = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0] ALU_PRE   = PH_W'(ALU_PHASE - 1);
  localparam logic [PH_W-1:0] FETCH_END = PH_W'(FETCH_LEN);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            single_q, single_d;
  logic            fetch_q, fetch_d;
  logic            alu_q, alu_d;
  logic            cs_q, cs_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      single_q <= 1'b0;
      fetch_q  <= 1'b0;
      alu_q    <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      single_q <= single_d;
      fetch_q  <= fetch_d;
      alu_q    <= alu_d;
      cs_q     <= cs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    single_d = single_q;
    cs_d     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d  = RUN;
        phase_d  = '0;
        single_d = 1'b0;
        cs_d     = 1'b1;
      end
      RUN: begin
        if (!hold) begin
          if (phase_q == LAST_PH) begin
            phase_d = '0;
            // A stepped cycle re-halts even if halt was dropped meanwhile.
            if (halt || single_q) begin
              state_d  = HALTED;
              single_d = 1'b0;
            end else begin
              cs_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      HALTED: begin
        if (!halt || step) begin
          state_d  = RUN;
          phase_d  = '0;
          single_d = halt;
          cs_d     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    fetch_d = (state_d == RUN) && (phase_d < FETCH_END);
    // Fires only on the increment into ALU_PHASE, so a held phase cannot repeat it.
    alu_d   = (state_q == RUN) && !hold && (phase_q == ALU_PRE);
  end

  assign clk         = sys_clk;
  assign fetch       = fetch_q;
  assign alu_ena     = alu_q;
  assign phase       = phase_q;
  assign cycle_start = cs_q;

`ifdef PHASE_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cs_d) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_phase_seq_gen.sv
// Scoreboard bench for phase_seq_gen: default-parameter unit plus a 4-phase unit.
// Directed cycles push expected outputs; a monitor pops and compares after each edge.
module tb_phase_seq_gen;

`ifdef PHASE_SEQ_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst_n = 1'b0, rst4_n = 1'b0;
  logic hold = 1'b0, halt = 1'b0, step = 1'b0;

  logic        clk_a, fetch_a, alu_a, cs_a;
  logic [3:0]  phase_a;
  logic [15:0] cnt_a;
  logic        clk_b, fetch_b, alu_b, cs_b;
  logic [1:0]  phase_b;
  logic [15:0] cnt_b;

  phase_seq_gen dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .hold(hold), .halt(halt), .step(step),
    .clk(clk_a), .fetch(fetch_a), .alu_ena(alu_a), .phase(phase_a),
    .cycle_start(cs_a), .cycle_cnt(cnt_a)
  );

  phase_seq_gen #(.NUM_PHASES(4), .FETCH_LEN(1), .ALU_PHASE(3), .PH_W(2)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst4_n), .hold(hold), .halt(halt), .step(step),
    .clk(clk_b), .fetch(fetch_b), .alu_ena(alu_b), .phase(phase_b),
    .cycle_start(cs_b), .cycle_cnt(cnt_b)
  );

  typedef struct {
    bit          unit;
    logic [3:0]  ph;
    logic        f;
    logic        a;
    logic        cs;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  event        sample_ev;
  logic [15:0] cnt_exp[2];

  task automatic push(input bit u, input int ph, input logic f, input logic a,
                      input logic cs, input string tag);
    exp_t e;
    if (cs) cnt_exp[u] = cnt_exp[u] + 16'd1;
    e.unit = u;
    e.ph   = 4'(ph);
    e.f    = f;
    e.a    = a;
    e.cs   = cs;
    e.cnt  = CNT_EN ? cnt_exp[u] : 16'h0000;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Drive inputs at a negedge and record what must appear after the next posedge.
  task automatic cyc(input bit u, input logic h, input logic hl, input logic st,
                     input int ph, input logic f, input logic a, input logic cs,
                     input string tag);
    hold = h;
    halt = hl;
    step = st;
    push(u, ph, f, a, cs, tag);
    @(negedge sys_clk);
  endtask

  exp_t        m_e;
  logic [23:0] m_act, m_req;

  initial begin
    forever begin
      @(posedge sys_clk or sample_ev);
      #1;
      if (sb.size() > 0) begin
        m_e = sb.pop_front();
        if (m_e.unit)
          m_act = {clk_b, 2'b00, phase_b, fetch_b, alu_b, cs_b, cnt_b};
        else
          m_act = {clk_a, phase_a, fetch_a, alu_a, cs_a, cnt_a};
        m_req = {sys_clk, m_e.ph, m_e.f, m_e.a, m_e.cs, m_e.cnt};
        checks++;
        if (m_act !== m_req) begin
          errors++;
          $display("FAIL %s: got clk=%b ph=%0d fetch=%b alu=%b cs=%b cnt=%h, required clk=%b ph=%0d fetch=%b alu=%b cs=%b cnt=%h",
                   m_e.tag, m_act[23], m_act[22:19], m_act[18], m_act[17], m_act[16], m_act[15:0],
                   m_req[23], m_req[22:19], m_req[18], m_req[17], m_req[16], m_req[15:0]);
        end
      end
    end
  end

  initial begin
    cnt_exp[0] = '0;
    cnt_exp[1] = '0;
    #1;
    push(0, 0, 0, 0, 0, "reset_a");
    ->sample_ev;
    #2;
    push(1, 0, 0, 0, 0, "reset_b");
    ->sample_ev;
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Two free-running periods; step pulses in RUN must be ignored.
    for (int k = 0; k < 16; k++)
      cyc(0, 0, 0, (k >= 9 && k < 11), k % 8, (k % 8) < 4, (k % 8) == 5, (k % 8) == 0, "period");

    // Hold three clocks at phase 5.
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, k, k < 4, k == 5, k == 0, "pre_hold");
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 5, 0, 0, 0, "hold");
    cyc(0, 0, 0, 0, 6, 0, 0, 0, "post_hold");
    cyc(0, 0, 0, 0, 7, 0, 0, 0, "post_hold");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, "hold_wrap");

    // Halt raised at phase 2 completes the cycle, then HALTED.
    cyc(0, 0, 0, 0, 1, 1, 0, 0, "pre_halt");
    cyc(0, 0, 0, 0, 2, 1, 0, 0, "pre_halt");
    for (int k = 3; k < 8; k++) cyc(0, 0, 1, 0, k, k < 4, k == 5, 0, "halt_finish");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "halted");
    cyc(0, 1, 1, 0, 0, 0, 0, 0, "halted_hold_ign");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, "resume");

    // Halt again, then single-step one full cycle with a hold+halt at the last phase.
    for (int k = 1; k < 8; k++) cyc(0, 0, 1, 0, k, k < 4, k == 5, 0, "to_halt");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "halted2");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "halted2");
    cyc(0, 0, 1, 1, 0, 1, 0, 1, "step_start");
    for (int k = 1; k < 8; k++) cyc(0, 0, 1, 0, k, k < 4, k == 5, 0, "step_run");
    cyc(0, 1, 1, 0, 7, 0, 0, 0, "hold_beats_halt");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "step_end");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "step_end");

`ifdef PHASE_SEQ_CYCLE_CNT_EN
    force dut_a.cnt_q = 16'hFFFF;
    #1;
    release dut_a.cnt_q;
    cnt_exp[0] = 16'hFFFF;
`endif
    cyc(0, 0, 0, 0, 0, 1, 0, 1, "cnt_wrap");
    for (int k = 1; k < 9; k++)
      cyc(0, 0, 0, 0, k % 8, (k % 8) < 4, (k % 8) == 5, (k % 8) == 0, "after_wrap");

    // Four-phase unit; hold must not delay the IDLE exit.
    rst4_n = 1'b1;
    cyc(1, 1, 0, 0, 0, 1, 0, 1, "b_idle_hold");
    for (int k = 1; k < 7; k++)
      cyc(1, 0, 0, 0, k % 4, (k % 4) < 1, (k % 4) == 3, (k % 4) == 0, "b_period");
    rst4_n = 1'b0;
    cnt_exp[1] = '0;
    push(1, 0, 0, 0, 0, "b_rst_mid");
    ->sample_ev;
    #2;

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge sys_clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
